// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the single-cycle RISC-V core.
// Word-organised synchronous RAM with byte/halfword/word loads and stores,
// sign/zero extension, request checking and a one-cycle ready/fault pulse.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_rd_en_i,
    input  logic        mem_wr_en_i,
    input  logic [31:0] mem_addr_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        mem_fault_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        DONE    = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic [1:0]  lo_q, lo_d;
    logic [2:0]  f3_q, f3_d;

    logic [31:0] mem_q [0:DEPTH-1];
    logic [31:0] rd_word_q;

    logic                  req_s;
    logic                  fault_s;
    logic                  we_s;
    logic                  re_s;
    logic [3:0]            be_s;
    logic [31:0]           wlane_s;
    logic [ADDR_WIDTH-1:0] widx_s;

    // Rejects conflicting enables, out-of-range addresses, illegal access
    // types and misaligned halfword/word accesses.
    function automatic logic req_fault(input logic        rd,
                                       input logic        wr,
                                       input logic [31:0] addr,
                                       input logic [2:0]  f3);
        logic bad_range;
        logic bad_type;
        bad_range = (addr >> (ADDR_WIDTH + 2)) != 32'd0;
        case (f3)
            3'b000:  bad_type = 1'b0;
            3'b001:  bad_type = addr[0];
            3'b010:  bad_type = (addr[1:0] != 2'b00);
            3'b100:  bad_type = wr;
            3'b101:  bad_type = wr | addr[0];
            default: bad_type = 1'b1;
        endcase
        return (rd & wr) | bad_range | bad_type;
    endfunction

    // Byte lanes touched by a store of the given type at the given offset.
    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] lo);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << lo;
            3'b001:  be = lo[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated so every enabled lane sees the right bytes.
    function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                                input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3)
            3'b000:  lanes = {4{wd[7:0]}};
            3'b001:  lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    // Picks the addressed byte/halfword out of a word and extends it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // A request is never acted on while reset is held, so no store can land
    // in the RAM during reset.
    assign req_s   = (mem_rd_en_i | mem_wr_en_i) & ~rst_i;
    assign fault_s = req_fault(mem_rd_en_i, mem_wr_en_i, mem_addr_i, mem_funct3_i);
    assign be_s    = store_be(mem_funct3_i, mem_addr_i[1:0]);
    assign wlane_s = store_lanes(mem_funct3_i, mem_wdata_i);
    assign widx_s  = mem_addr_i[ADDR_WIDTH+1:2];

    // Next-state and registered-output values for the request FSM.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        fault_d = 1'b0;
        rdata_d = rdata_q;
        lo_d    = lo_q;
        f3_d    = f3_q;
        we_s    = 1'b0;
        re_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    lo_d = mem_addr_i[1:0];
                    f3_d = mem_funct3_i;
                    if (fault_s) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = 32'h0000_0000;
                    end else if (mem_wr_en_i) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        we_s    = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        re_s    = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                state_d = DONE;
                ready_d = 1'b1;
                rdata_d = load_extend(rd_word_q, lo_q, f3_q);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears outputs immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'h0000_0000;
            lo_q    <= 2'b00;
            f3_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            lo_q    <= lo_d;
            f3_q    <= f3_d;
        end
    end

    // RAM array: byte-enabled write and registered word read, no reset.
    always_ff @(posedge clk_i) begin
        if (we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[widx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
        if (re_s) begin
            rd_word_q <= mem_q[widx_s];
        end
    end

    assign mem_rdata_o = rdata_q;
    assign mem_ready_o = ready_q;
    assign mem_fault_o = fault_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core. It services the load/store requests that the control path raises on `mem_rd_en`/`mem_wr_en`, holding a word-organised synchronous RAM. It performs byte/halfword/word access selected by `funct3`, with sign/zero extension and alignment checking. It returns a one-cycle `mem_ready` pulse, plus `mem_fault` for bad requests, so the core can stall until the access completes.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; RAM depth = 2^ADDR_WIDTH 32-bit words (4 KiB at default).
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `mem_rd_en`  in  1: load request; held stable by the core until `mem_ready`.
- `mem_wr_en`  in  1: store request; held stable by the core until `mem_ready`.
- `mem_addr`  in  32: byte address (ALU result, rs1 + imm).
- `mem_funct3`  in  3: access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_wdata`  in  32: store data (rs2); low bytes used for SB/SH.
- `mem_rdata`  out  32: extended load result; valid while `mem_ready`=1 and `mem_fault`=0.
- `mem_ready`  out  1: one-cycle completion pulse.
- `mem_fault`  out  1: asserted with `mem_ready` when the request was rejected.

## Operation
- FSM states: IDLE, RD_WAIT, DONE.
- IDLE: a request is accepted on any edge where `mem_rd_en` or `mem_wr_en` is 1; `mem_addr`, `mem_funct3` and the type are latched.
- Fault check at acceptance, combinational on the inputs. Any of the following is a fault:
  - `mem_rd_en` and `mem_wr_en` both 1.
  - `mem_addr[31:ADDR_WIDTH+2]` nonzero.
  - Load `funct3` not in {000,001,010,100,101}, or store `funct3` not in {000,001,010}.
  - H/HU/SH with `addr[0]`=1.
  - W/SW with `addr[1:0]`≠00.
- Fault: no RAM access; next state DONE with `mem_fault`=1 and `mem_rdata`=0.
- Store, no fault: RAM written at the accepting edge using byte enables.
  - SB: lane `addr[1:0]` ← `wdata[7:0]`.
  - SH: lanes {`addr[1]`*2, +1} ← `wdata[15:0]`.
  - SW: all four lanes ← `wdata`.
  - Unselected bytes are unchanged. Next state DONE.
- Load, no fault: RAM read of word `addr[ADDR_WIDTH+1:2]` is registered at the accepting edge; next state RD_WAIT.
- RD_WAIT: select the byte/halfword by the latched `addr[1:0]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Register the result into `mem_rdata`; next state DONE.
- DONE: `mem_ready`=1 for exactly this cycle; request inputs ignored; next state IDLE unconditionally.
- IDLE with no request: stay; `mem_ready`=0, `mem_fault`=0; `mem_rdata` holds its last value.
- Back-to-back: a request held high after DONE is treated as a new request in IDLE. The core must deassert enables or change the request on the edge that samples `mem_ready`.
- RAM contents are not reset and are undefined at power-up.

## Timing
- Reset values: state IDLE, `mem_ready`=0, `mem_fault`=0, `mem_rdata`=0.
- Reset takes effect immediately on assertion, asynchronously; the FSM leaves IDLE only on the first rising edge after deassertion.
- Store latency: accept at edge N, `mem_ready` high during cycle N+1 (1 stall cycle).
- Load latency: accept at edge N, RD_WAIT cycle N+1, `mem_ready` with data during cycle N+2 (2 stall cycles).
- Fault latency: `mem_ready`/`mem_fault` during cycle N+1.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset during RD_WAIT/DONE: pending load dropped, no `mem_ready`. A store already written at its accepting edge persists.
- Throughput: at most one access every 2 cycles (store) or 3 cycles (load).

## Test plan
- Reset sequencing: assert `rst` mid-RD_WAIT -> outputs go to 0 immediately; no `mem_ready` afterwards until a new request is issued.
- SW 0xDEADBEEF @0x10, then LW @0x10 -> store `mem_ready` 1 cycle after accept; load `mem_ready` 2 cycles after accept with `mem_rdata`=0xDEADBEEF, `mem_fault`=0.
- SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
- SH 0x1234 @0x12, then LH @0x12 -> 0x00001234; LHU @0x10 -> 0x0000BEEF; LH @0x10 -> 0xFFFFBEEF.
- Faults, each -> `mem_ready`=1 and `mem_fault`=1 one cycle after accept, `mem_rdata`=0, RAM unchanged (verified by a following LW):
  - LW @0x11; SH @0x13; SW @0x00001000 (ADDR_WIDTH=10); load with `funct3`=011; both enables high.
- Held request: keep LW @0x10 asserted for 6 cycles -> `mem_ready` pulses on cycles 2 and 5, each one cycle wide.
